// File: rtl/axi_line_fetcher_pkg.sv
// Shared definitions for the instruction-side line fetcher: address width,
// AXI response codes and the fetch state encoding.
package axi_line_fetcher_pkg;

  localparam int unsigned ADDR_WIDTH = 32;

  localparam logic [1:0] AXI_RESP_OKAY   = 2'b00;
  localparam logic [1:0] AXI_RESP_EXOKAY = 2'b01;
  localparam logic [1:0] AXI_RESP_SLVERR = 2'b10;
  localparam logic [1:0] AXI_RESP_DECERR = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_AR   = 2'd1,
    ST_R    = 2'd2,
    ST_RESP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/axi_read_if.sv
// AXI read address and read data channels, 32-bit data.
interface axi_read_if;

  logic [axi_line_fetcher_pkg::ADDR_WIDTH-1:0] araddr;
  logic [7:0]                                  arlen;
  logic                                        arvalid;
  logic                                        arready;
  logic [31:0]                                 rdata;
  logic                                        rvalid;
  logic                                        rready;
  logic                                        rlast;
  logic [1:0]                                  rresp;

  modport master (
    output araddr, arlen, arvalid, rready,
    input  arready, rdata, rvalid, rlast, rresp
  );

  modport slave (
    input  araddr, arlen, arvalid, rready,
    output arready, rdata, rvalid, rlast, rresp
  );

endinterface

// File: rtl/axi_line_fetcher.sv
// AXI read master that refills one cache line per request with a single
// INCR burst and returns the assembled line plus an error flag.
module axi_line_fetcher #(
  parameter int unsigned ADDR_WIDTH = axi_line_fetcher_pkg::ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BEATS      = 4
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          req_valid,
  output logic                          req_ready,
  input  logic [ADDR_WIDTH-1:0]         req_addr,
  output logic                          resp_valid,
  input  logic                          resp_ready,
  output logic [BEATS*DATA_WIDTH-1:0]   resp_line,
  output logic                          resp_err,
  axi_read_if.master                    axi_if
);

  import axi_line_fetcher_pkg::*;

  localparam int unsigned LINE_W = BEATS * DATA_WIDTH;
  localparam int unsigned CNT_W  = $clog2(BEATS + 1);
  localparam logic [ADDR_WIDTH-1:0] OFF_MASK = ADDR_WIDTH'(BEATS * 4 - 1);

  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] araddr_q, araddr_d;
  logic                  arvalid_q, arvalid_d;
  logic                  resp_valid_q, resp_valid_d;
  logic                  resp_err_q, resp_err_d;
  logic [LINE_W-1:0]     line_q, line_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  logic req_ready_c, rready_c;
  logic req_hs, ar_hs, r_hs, resp_hs;

  assign req_ready_c = (state_q == ST_IDLE);
  assign rready_c    = (state_q == ST_R);

  assign req_hs  = req_valid & req_ready_c;
  assign ar_hs   = arvalid_q & axi_if.arready;
  assign r_hs    = axi_if.rvalid & rready_c;
  assign resp_hs = resp_valid_q & resp_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (req_hs)                    state_d = ST_AR;
      ST_AR:   if (ar_hs)                     state_d = ST_R;
      ST_R:    if (r_hs && axi_if.rlast)      state_d = ST_RESP;
      ST_RESP: if (resp_hs)                   state_d = ST_IDLE;
      default:                                state_d = ST_IDLE;
    endcase
  end

  // Next values for the registered outputs, line buffer and beat counter.
  always_comb begin
    araddr_d     = araddr_q;
    arvalid_d    = arvalid_q;
    resp_valid_d = resp_valid_q;
    resp_err_d   = resp_err_q;
    line_d       = line_q;
    cnt_d        = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (req_hs) begin
          araddr_d   = req_addr & ~OFF_MASK;
          arvalid_d  = 1'b1;
          line_d     = '0;
          resp_err_d = 1'b0;
          cnt_d      = '0;
        end
      end
      ST_AR: begin
        if (ar_hs) arvalid_d = 1'b0;
      end
      ST_R: begin
        if (r_hs) begin
          if (cnt_q < CNT_W'(BEATS)) begin
            for (int unsigned k = 0; k < BEATS; k++) begin
              if (cnt_q == CNT_W'(k)) line_d[k*DATA_WIDTH +: DATA_WIDTH] = axi_if.rdata;
            end
            cnt_d = cnt_q + CNT_W'(1);
            if (axi_if.rresp != AXI_RESP_OKAY) resp_err_d = 1'b1;
          end else begin
            // Beyond the line: swallow the beat but flag the overrun.
            resp_err_d = 1'b1;
          end
          if (axi_if.rlast) begin
            resp_valid_d = 1'b1;
            if (cnt_q < CNT_W'(BEATS - 1)) resp_err_d = 1'b1;
          end
        end
      end
      ST_RESP: begin
        if (resp_hs) resp_valid_d = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      araddr_q     <= '0;
      arvalid_q    <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_err_q   <= 1'b0;
      line_q       <= '0;
      cnt_q        <= '0;
    end else begin
      araddr_q     <= araddr_d;
      arvalid_q    <= arvalid_d;
      resp_valid_q <= resp_valid_d;
      resp_err_q   <= resp_err_d;
      line_q       <= line_d;
      cnt_q        <= cnt_d;
    end
  end

  assign req_ready      = req_ready_c;
  assign resp_valid     = resp_valid_q;
  assign resp_line      = line_q;
  assign resp_err       = resp_err_q;
  assign axi_if.araddr  = araddr_q;
  assign axi_if.arlen   = 8'(BEATS - 1);
  assign axi_if.arvalid = arvalid_q;
  assign axi_if.rready  = rready_c;

endmodule

// File: tb/tb_axi_line_fetcher.sv
// Directed and randomized bench for axi_line_fetcher; the bench plays the
// AXI slave (memory word i holds i) and predicts each line from the beat list.
module tb_axi_line_fetcher;

  import axi_line_fetcher_pkg::*;

  localparam int BEATS  = 4;
  localparam int LINE_W = BEATS * 32;

  logic              clk = 1'b0;
  logic              rst_n;
  logic              req_valid;
  logic              req_ready;
  logic [31:0]       req_addr;
  logic              resp_valid;
  logic              resp_ready;
  logic [LINE_W-1:0] resp_line;
  logic              resp_err;

  axi_read_if axi ();

  axi_line_fetcher #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .BEATS(BEATS)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_line(resp_line),
    .resp_err(resp_err),
    .axi_if(axi)
  );

  always #5 clk = ~clk;

  int total = 0;
  int fails = 0;
  logic [31:0] cur_addr;
  logic [31:0] bdata[$];
  logic        bbad[$];

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Expected result from the list of beats the slave actually sent.
  function automatic void model(output logic [LINE_W-1:0] line, output logic err);
    int n = bdata.size();
    line = '0;
    err  = (n != BEATS);
    for (int k = 0; k < n && k < BEATS; k++) begin
      line[k*32 +: 32] = bdata[k];
      if (bbad[k]) err = 1'b1;
    end
  endfunction

  task automatic issue_req(input logic [31:0] addr, input int ar_delay);
    logic [31:0] exp_a;
    exp_a = addr & ~32'(BEATS * 4 - 1);
    chk("req_ready_idle", 128'(req_ready), 128'(1));
    req_valid = 1'b1;
    req_addr  = addr;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    chk("arvalid_set", 128'(axi.arvalid), 128'(1));
    chk("araddr", 128'(axi.araddr), 128'(exp_a));
    chk("arlen", 128'(axi.arlen), 128'(BEATS - 1));
    chk("req_ready_busy", 128'(req_ready), 128'(0));
    for (int i = 0; i < ar_delay; i++) begin
      tick();
      chk("arvalid_hold", 128'(axi.arvalid), 128'(1));
      chk("araddr_hold", 128'(axi.araddr), 128'(exp_a));
    end
    axi.arready = 1'b1;
    tick();
    axi.arready = 1'b0;
    chk("arvalid_drop", 128'(axi.arvalid), 128'(0));
    chk("rready_in_r", 128'(axi.rready), 128'(1));
    cur_addr = exp_a;
  endtask

  task automatic send_beats(input int n, input int bad_idx, input logic [1:0] bad_resp,
                            input int gmin, input int gmax, input int stop_after);
    int gap;
    bdata.delete();
    bbad.delete();
    for (int i = 0; i < n; i++) begin
      if (i == stop_after) return;
      gap = $urandom_range(gmax, gmin);
      for (int g = 0; g < gap; g++) tick();
      axi.rvalid = 1'b1;
      axi.rdata  = 32'((cur_addr >> 2) + 32'(i));
      axi.rresp  = (i == bad_idx) ? bad_resp : AXI_RESP_OKAY;
      axi.rlast  = (i == n - 1);
      bdata.push_back(axi.rdata);
      bbad.push_back(i == bad_idx);
      tick();
      axi.rvalid = 1'b0;
      axi.rlast  = 1'b0;
      axi.rdata  = $urandom;
      axi.rresp  = AXI_RESP_OKAY;
    end
  endtask

  task automatic finish_resp(input int stall, input bit poke);
    logic [LINE_W-1:0] exp_line;
    logic              exp_err;
    model(exp_line, exp_err);
    chk("resp_valid_set", 128'(resp_valid), 128'(1));
    chk("resp_line", 128'(resp_line), 128'(exp_line));
    chk("resp_err", 128'(resp_err), 128'(exp_err));
    chk("rready_resp", 128'(axi.rready), 128'(0));
    for (int i = 0; i < stall; i++) begin
      if (poke) begin
        req_valid = 1'b1;
        req_addr  = $urandom;
      end
      tick();
      chk("stall_valid", 128'(resp_valid), 128'(1));
      chk("stall_line", 128'(resp_line), 128'(exp_line));
      chk("stall_err", 128'(resp_err), 128'(exp_err));
      chk("stall_no_ar", 128'(axi.arvalid), 128'(0));
    end
    req_valid  = 1'b0;
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
    chk("resp_valid_drop", 128'(resp_valid), 128'(0));
    chk("req_ready_back", 128'(req_ready), 128'(1));
    chk("line_retained", 128'(resp_line), 128'(exp_line));
    chk("err_retained", 128'(resp_err), 128'(exp_err));
  endtask

  initial begin
    int n, bad, stall;
    rst_n       = 1'b0;
    req_valid   = 1'b0;
    req_addr    = '0;
    resp_ready  = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    axi.rdata   = '0;
    axi.rresp   = AXI_RESP_OKAY;

    // Reset with random inputs toggling.
    for (int i = 0; i < 3; i++) begin
      req_valid   = 1'($urandom);
      req_addr    = $urandom;
      resp_ready  = 1'($urandom);
      axi.arready = 1'($urandom);
      axi.rvalid  = 1'($urandom);
      axi.rlast   = 1'($urandom);
      axi.rdata   = $urandom;
      tick();
      chk("rst_arvalid", 128'(axi.arvalid), 128'(0));
      chk("rst_rready", 128'(axi.rready), 128'(0));
      chk("rst_resp_valid", 128'(resp_valid), 128'(0));
      chk("rst_line", 128'(resp_line), 128'(0));
      chk("rst_err", 128'(resp_err), 128'(0));
      chk("rst_araddr", 128'(axi.araddr), 128'(0));
    end
    req_valid   = 1'b0;
    resp_ready  = 1'b0;
    axi.arready = 1'b0;
    axi.rvalid  = 1'b0;
    axi.rlast   = 1'b0;
    rst_n       = 1'b1;
    tick();
    chk("post_rst_req_ready", 128'(req_ready), 128'(1));
    chk("post_rst_arvalid", 128'(axi.arvalid), 128'(0));

    // Basic fetch of the line containing 0x1234.
    issue_req(32'h0000_1234, 0);
    chk("basic_araddr_lit", 128'(cur_addr), 128'(32'h0000_1230));
    send_beats(4, -1, AXI_RESP_OKAY, 0, 0, -1);
    chk("basic_line_lit", 128'(resp_line), 128'h0000048f_0000048e_0000048d_0000048c);
    finish_resp(0, 1'b0);

    // Slow arready.
    issue_req(32'h0000_1234, 5);
    send_beats(4, -1, AXI_RESP_OKAY, 0, 0, -1);
    finish_resp(0, 1'b0);

    // Gapped beats and stalled consumer with ignored requests.
    issue_req($urandom, 0);
    send_beats(4, -1, AXI_RESP_OKAY, 2, 2, -1);
    finish_resp(3, 1'b1);

    // SLVERR on beat 2.
    issue_req($urandom, 1);
    send_beats(4, 2, AXI_RESP_SLVERR, 0, 1, -1);
    chk("slverr_flag", 128'(resp_err), 128'(1));
    finish_resp(0, 1'b0);

    // Early rlast on beat 1.
    issue_req($urandom, 0);
    send_beats(2, -1, AXI_RESP_OKAY, 0, 1, -1);
    chk("early_upper_zero", 128'(resp_line[127:64]), 128'(0));
    finish_resp(1, 1'b0);

    // Five beats, rlast on the fifth.
    issue_req($urandom, 0);
    send_beats(5, -1, AXI_RESP_OKAY, 0, 1, -1);
    chk("overrun_flag", 128'(resp_err), 128'(1));
    finish_resp(0, 1'b0);

    // Reset in R after two beats, then a clean fetch.
    issue_req($urandom, 0);
    send_beats(4, -1, AXI_RESP_OKAY, 0, 0, 2);
    rst_n = 1'b0;
    #1;
    chk("midrst_rready", 128'(axi.rready), 128'(0));
    chk("midrst_req_ready", 128'(req_ready), 128'(1));
    chk("midrst_line", 128'(resp_line), 128'(0));
    chk("midrst_resp_valid", 128'(resp_valid), 128'(0));
    tick();
    rst_n = 1'b1;
    tick();
    issue_req($urandom, 0);
    send_beats(4, -1, AXI_RESP_OKAY, 0, 1, -1);
    finish_resp(0, 1'b0);

    // Randomized transactions.
    for (int t = 0; t < 25; t++) begin
      n     = ($urandom_range(3, 0) == 0) ? int'($urandom_range(6, 1)) : BEATS;
      bad   = ($urandom_range(2, 0) == 0) ? int'($urandom_range(n - 1, 0)) : -1;
      stall = $urandom_range(2, 0);
      issue_req($urandom, $urandom_range(3, 0));
      send_beats(n, bad, 2'($urandom_range(3, 1)), 0, 2, -1);
      finish_resp(stall, 1'($urandom));
    end

    $display("%0d/%0d checks passed", total - fails, total);
    $finish;
  end

endmodule
